otp_decrypt_stream: RTL and testbench

Receive-side counterpart of the OTP encryption stage. It consumes 64-bit cipher words through a valid/ready handshake and regenerates the keystream with an internal 64-bit LFSR that advances once per accepted word. Each word passes through the inverse of the bit-reversal/complement/bit-reversal chain, which reduces to a bitwise complement, and is then XORed with the keystream. Recovered plaintext leaves through a 2-stage registered pipeline with backpressure. The block sits directly downstream of the encryptor, on the link or memory side.

---
 rtl/otp_decrypt_stream.sv | 98 +++++++++
 tb/tb_otp_decrypt_stream.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/otp_decrypt_stream.sv
// Stream OTP decryptor: regenerates the 64-bit LFSR keystream per accepted word
// and emits ~cipher ^ key through a two-stage registered pipeline with backpressure.
module otp_decrypt_stream #(
   parameter logic [63:0] SEED  = 64'h0000_0000_0000_0001,
   parameter int          CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             resync,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [63:0]      cipher,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      plain,
   output logic [CNT_W-1:0] word_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [63:0]      lfsr_q, lfsr_d;
   logic [63:0]      s1_data_q, s1_data_d;
   logic             s1_vld_q, s1_vld_d;
   logic [63:0]      s2_data_q, s2_data_d;
   logic             s2_vld_q, s2_vld_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic s2_free, s1_free, accept, move, deliver;

   assign s2_free  = !s2_vld_q || out_ready;
   assign s1_free  = !s1_vld_q || s2_free;
   assign in_ready = s1_free && !resync;
   assign accept   = in_valid && in_ready;
   assign move     = s1_vld_q && s2_free;
   assign deliver  = s2_vld_q && out_ready;

   always_comb begin
      lfsr_d    = lfsr_q;
      s1_data_d = s1_data_q;
      s1_vld_d  = s1_vld_q;
      s2_data_d = s2_data_q;
      s2_vld_d  = s2_vld_q;
      cnt_d     = cnt_q;

      if (resync) begin
         // Realign the keystream and drop anything in flight, including a
         // word leaving s2 this cycle.
         lfsr_d   = SEED;
         s1_vld_d = 1'b0;
         s2_vld_d = 1'b0;
         cnt_d    = '0;
      end else begin
         if (accept)
            lfsr_d = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};

         // Stage 1: data only loads on accept so plain never picks up junk.
         if (s1_free) begin
            s1_vld_d = accept;
            if (accept)
               s1_data_d = ~cipher ^ lfsr_q;
         end

         // Stage 2
         if (move) begin
            s2_vld_d  = 1'b1;
            s2_data_d = s1_data_q;
         end else if (out_ready) begin
            s2_vld_d = 1'b0;
         end

         if (deliver)
            cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q    <= SEED;
         s1_data_q <= '0;
         s1_vld_q  <= 1'b0;
         s2_data_q <= '0;
         s2_vld_q  <= 1'b0;
         cnt_q     <= '0;
      end else begin
         lfsr_q    <= lfsr_d;
         s1_data_q <= s1_data_d;
         s1_vld_q  <= s1_vld_d;
         s2_data_q <= s2_data_d;
         s2_vld_q  <= s2_vld_d;
         cnt_q     <= cnt_d;
      end
   end

   assign out_valid = s2_vld_q;
   assign plain     = s2_data_q;
   assign word_cnt  = cnt_q;

endmodule

// File: tb/tb_otp_decrypt_stream.sv
// Directed bench for otp_decrypt_stream; a second instance with a 4-bit counter
// shares the inputs to exercise counter wrap.
module tb_otp_decrypt_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        resync = 1'b0;
   logic        in_valid = 1'b0;
   logic [63:0] cipher = '0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid;
   logic [63:0] plain;
   logic [31:0] word_cnt;
   logic        in_ready4, out_valid4;
   logic [63:0] plain4;
   logic [3:0]  word_cnt4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   otp_decrypt_stream #(.SEED(64'h1), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .resync(resync), .in_valid(in_valid), .in_ready(in_ready),
      .cipher(cipher), .out_valid(out_valid), .out_ready(out_ready), .plain(plain),
      .word_cnt(word_cnt)
   );

   otp_decrypt_stream #(.SEED(64'h1), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .resync(resync), .in_valid(in_valid), .in_ready(in_ready4),
      .cipher(cipher), .out_valid(out_valid4), .out_ready(out_ready), .plain(plain4),
      .word_cnt(word_cnt4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step();
      rst = 1'b0; in_valid = 1'b0; resync = 1'b0; out_ready = 1'b0; cipher = '0;
      step();
      step();
      rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (plain !== 64'h0) begin errors++; $display("FAIL reset_plain: got %h expected 0", plain); end
      checks++; if (word_cnt !== 32'h0) begin errors++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
   endtask

   task automatic test_single();
      test_reset();
      step();
      in_valid = 1'b1; cipher = 64'hFFFF_FFFF_FFFF_FFE7; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", out_valid); end
      step();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
      checks++; if (plain !== 64'h19) begin errors++; $display("FAIL single_plain: got %h expected 19", plain); end
      step();
      checks++; if (word_cnt !== 32'd1) begin errors++; $display("FAIL single_cnt: got %0d expected 1", word_cnt); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp [3];
      exp[0] = 64'h18; exp[1] = 64'h1B; exp[2] = 64'h1D;
      test_reset();
      step();
      in_valid = 1'b1; cipher = 64'hFFFF_FFFF_FFFF_FFE6; out_ready = 1'b1;
      step();
      step();
      for (int i = 0; i < 3; i++) begin
         if (i == 1) in_valid = 1'b0;
         checks++; if (out_valid !== 1'b1 || plain !== exp[i]) begin
            errors++; $display("FAIL b2b_word%0d: got v=%b %h expected v=1 %h", i, out_valid, plain, exp[i]);
         end
         step();
      end
      checks++; if (word_cnt !== 32'd3) begin errors++; $display("FAIL b2b_cnt: got %0d expected 3", word_cnt); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_backpressure();
      test_reset();
      step();
      in_valid = 1'b1; cipher = 64'hFFFF_FFFF_FFFF_FFE7; out_ready = 1'b0;
      step();
      cipher = 64'hFFFF_FFFF_FFFF_FFE6;
      step();
      cipher = 64'hFFFF_FFFF_FFFF_FFE5;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
      checks++; if (plain !== 64'h19) begin errors++; $display("FAIL bp_plain0: got %h expected 19", plain); end
      step();
      checks++; if (in_ready !== 1'b0 || plain !== 64'h19 || out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_hold: got rdy=%b v=%b %h expected rdy=0 v=1 19", in_ready, out_valid, plain);
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (plain !== 64'h1B || out_valid !== 1'b1) begin errors++; $display("FAIL bp_plain1: got v=%b %h expected v=1 1b", out_valid, plain); end
      step();
      checks++; if (plain !== 64'h1E || out_valid !== 1'b1) begin errors++; $display("FAIL bp_plain2: got v=%b %h expected v=1 1e", out_valid, plain); end
      step();
      checks++; if (word_cnt !== 32'd3 || out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_cnt: got cnt=%0d v=%b expected cnt=3 v=0", word_cnt, out_valid);
      end
   endtask

   task automatic test_resync();
      test_reset();
      step();
      in_valid = 1'b1; cipher = 64'hFFFF_FFFF_FFFF_FFE7; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      checks++; if (word_cnt !== 32'd1) begin errors++; $display("FAIL rs_pre_cnt: got %0d expected 1", word_cnt); end
      out_ready = 1'b0; in_valid = 1'b1; cipher = 64'hFFFF_FFFF_FFFF_FFE6;
      step();
      step();
      resync = 1'b1; out_ready = 1'b1; cipher = 64'hFFFF_FFFF_FFFF_FFE6;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rs_in_ready: got %b expected 0", in_ready); end
      step();
      resync = 1'b0; in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || word_cnt !== 32'd0) begin
         errors++; $display("FAIL rs_clear: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, word_cnt);
      end
      step();
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rs_not_accepted: got %b expected 0", out_valid); end
      in_valid = 1'b1; cipher = 64'hFFFF_FFFF_FFFF_FFE7;
      step();
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1 || plain !== 64'h19) begin
         errors++; $display("FAIL rs_seed_key: got v=%b %h expected v=1 19", out_valid, plain);
      end
   endtask

   task automatic test_async_reset();
      test_reset();
      step();
      in_valid = 1'b1; cipher = 64'hFFFF_FFFF_FFFF_FFE7; out_ready = 1'b1;
      step();
      cipher = 64'hFFFF_FFFF_FFFF_FFE6;
      step();
      in_valid = 1'b0;
      step();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b1 || plain !== 64'h1B || word_cnt !== 32'd1) begin
         errors++; $display("FAIL ar_pre: got v=%b %h cnt=%0d expected v=1 1b cnt=1", out_valid, plain, word_cnt);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || plain !== 64'h0 || word_cnt !== 32'd0) begin
         errors++; $display("FAIL ar_immediate: got v=%b %h cnt=%0d expected v=0 0 cnt=0", out_valid, plain, word_cnt);
      end
      step();
      step();
      rst = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b1; cipher = 64'hFFFF_FFFF_FFFF_FFE7;
      step();
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b1 || plain !== 64'h19) begin
         errors++; $display("FAIL ar_seed_key: got v=%b %h expected v=1 19", out_valid, plain);
      end
   endtask

   task automatic test_cnt_wrap();
      test_reset();
      step();
      in_valid = 1'b1; cipher = 64'h0; out_ready = 1'b1;
      repeat (17) step();
      in_valid = 1'b0;
      repeat (3) step();
      checks++; if (word_cnt4 !== 4'd1) begin errors++; $display("FAIL wrap_cnt4: got %0d expected 1", word_cnt4); end
      checks++; if (word_cnt !== 32'd17) begin errors++; $display("FAIL wrap_cnt32: got %0d expected 17", word_cnt); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_resync();
      test_async_reset();
      test_cnt_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
